alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequencer that runs one command per three cycles against an external ALU
// and keeps a 4 x 8-bit register file, flags and a sticky illegal-op error.
`timescale 1ns/1ps
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [3:0] CmdOp,
    input  logic [1:0] CmdRa,
    input  logic [1:0] CmdRb,
    input  logic [1:0] CmdRd,
    input  logic [7:0] CmdImm,
    output logic [7:0] AluA,
    output logic [7:0] AluB,
    output logic [3:0] AluSel,
    input  logic [7:0] AluS,
    input  logic       AluCarry,
    input  logic       AluOverflow,
    input  logic       AluSign,
    input  logic       AluZero,
    output logic       DoneValid,
    output logic [7:0] DoneData,
    output logic [3:0] Flags,
    output logic       Err,
    input  logic [1:0] RdAddr,
    output logic [7:0] RdData
);

    localparam logic [3:0] OpLoadi = 4'b1000;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  ra_q, ra_d;
    logic [1:0]  rb_q, rb_d;
    logic [1:0]  rd_q, rd_d;
    logic [7:0]  imm_q, imm_d;
    logic [7:0]  regs_q [4];
    logic [7:0]  regs_d [4];
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic [7:0]  done_data_q, done_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            done_data_q <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            done_data_q <= done_data_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        flags_d     = flags_q;
        err_d       = err_q;
        done_data_d = done_data_q;
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (CmdValid) begin
                    op_d    = CmdOp;
                    ra_d    = CmdRa;
                    rb_d    = CmdRb;
                    rd_d    = CmdRd;
                    imm_d   = CmdImm;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StDone;
                // Operands were sampled from regs_q, so Rd may alias Ra/Rb safely.
                if (!op_q[3]) begin
                    regs_d[rd_q] = AluS;
                    flags_d      = {AluCarry, AluOverflow, AluSign, AluZero};
                    done_data_d  = AluS;
                end else if (op_q == OpLoadi) begin
                    regs_d[rd_q] = imm_q;
                    done_data_d  = imm_q;
                end else begin
                    err_d       = 1'b1;
                    done_data_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        CmdReady  = 1'b0;
        DoneValid = 1'b0;
        DoneData  = '0;
        AluA      = '0;
        AluB      = '0;
        AluSel    = '0;
        unique case (state_q)
            StIdle: CmdReady = !rst;
            StExec: begin
                AluA   = regs_q[ra_q];
                AluB   = regs_q[rb_q];
                AluSel = op_q;
            end
            StDone: begin
                DoneValid = 1'b1;
                DoneData  = done_data_q;
            end
            default: ;
        endcase
    end

    assign Flags  = flags_q;
    assign Err    = err_q;
    assign RdData = regs_q[RdAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a result scoreboard.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       CmdValid;
    logic       CmdReady;
    logic [3:0] CmdOp;
    logic [1:0] CmdRa, CmdRb, CmdRd;
    logic [7:0] CmdImm;
    logic [7:0] AluA, AluB;
    logic [3:0] AluSel;
    logic [7:0] AluS;
    logic       AluCarry, AluOverflow, AluSign, AluZero;
    logic       DoneValid;
    logic [7:0] DoneData;
    logic [3:0] Flags;
    logic       Err;
    logic [1:0] RdAddr;
    logic [7:0] RdData;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_regs [4];
    logic [3:0] m_flags;
    logic       m_err;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOp      (CmdOp),
        .CmdRa      (CmdRa),
        .CmdRb      (CmdRb),
        .CmdRd      (CmdRd),
        .CmdImm     (CmdImm),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluSel     (AluSel),
        .AluS       (AluS),
        .AluCarry   (AluCarry),
        .AluOverflow(AluOverflow),
        .AluSign    (AluSign),
        .AluZero    (AluZero),
        .DoneValid  (DoneValid),
        .DoneData   (DoneData),
        .Flags      (Flags),
        .Err        (Err),
        .RdAddr     (RdAddr),
        .RdData     (RdData)
    );

    // Returns {carry, overflow, sign, zero, result}.
    function automatic logic [11:0] alu_f(input logic [3:0] sel, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] s;
        logic       c, v;
        w = '0; s = '0; c = 1'b0; v = 1'b0;
        case (sel)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; s = w[7:0]; c = w[8];
                        v = (a[7] == b[7]) && (s[7] != a[7]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; s = w[7:0]; c = w[8];
                        v = (a[7] != b[7]) && (s[7] != a[7]); end
            4'd2: s = a & b;
            4'd3: s = a | b;
            4'd4: s = a ^ b;
            4'd5: s = ~a;
            4'd6: begin s = {a[6:0], 1'b0}; c = a[7]; end
            4'd7: begin s = {1'b0, a[7:1]}; c = a[0]; end
            default: ;
        endcase
        return {c, v, s[7], (s == 8'h00), s};
    endfunction

    always_comb {AluCarry, AluOverflow, AluSign, AluZero, AluS} = alu_f(AluSel, AluA, AluB);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags = '0;
        m_err   = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic [7:0] imm);
        exp_t        e;
        logic [11:0] r;
        logic [7:0]  a_exp, b_exp;
        int          n;
        a_exp   = m_regs[ra];
        b_exp   = m_regs[rb];
        e.flags = m_flags;
        e.err   = m_err;
        if (!op[3]) begin
            r          = alu_f(op, a_exp, b_exp);
            e.data     = r[7:0];
            e.flags    = r[11:8];
            m_regs[rd] = r[7:0];
        end else if (op == 4'b1000) begin
            e.data     = imm;
            m_regs[rd] = imm;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        m_flags = e.flags;
        m_err   = e.err;
        sb.push_back(e);

        @(negedge clk);
        CmdValid = 1'b1; CmdOp = op; CmdRa = ra; CmdRb = rb; CmdRd = rd; CmdImm = imm;
        RdAddr   = rd;
        n = 0;
        while (!CmdReady && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", 16'(CmdReady), 16'd1);
        @(posedge clk); #1;
        CmdValid = 1'b0;
        chk("exec_alu_a", 16'(AluA), 16'(a_exp));
        chk("exec_alu_b", 16'(AluB), 16'(b_exp));
        chk("exec_alu_sel", 16'(AluSel), 16'(op));
        chk("exec_no_done", 16'(DoneValid), 16'd0);
        chk("exec_not_ready", 16'(CmdReady), 16'd0);

        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!DoneValid && n < 4);
        chk("done_latency", 16'(n), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_data", 16'(DoneData), 16'(e.data));
            chk("flags", 16'(Flags), 16'(e.flags));
            chk("err", 16'(Err), 16'(e.err));
        end
        chk("rd_data", 16'(RdData), 16'(m_regs[rd]));

        @(posedge clk); #1;
        chk("done_one_cycle", 16'(DoneValid), 16'd0);
        chk("idle_ready", 16'(CmdReady), 16'd1);
        chk("idle_alu_sel", 16'(AluSel), 16'd0);
    endtask

    initial begin
        exp_t        e;
        logic [11:0] r;
        int          acc, dn;

        rst = 1'b1; CmdValid = 1'b0; CmdOp = '0; CmdRa = '0; CmdRb = '0; CmdRd = '0;
        CmdImm = '0; RdAddr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 16'(CmdReady), 16'd0);
        chk("rst_done_valid", 16'(DoneValid), 16'd0);
        chk("rst_done_data", 16'(DoneData), 16'd0);
        chk("rst_alu", 16'({AluA, AluB} | 16'(AluSel)), 16'd0);
        chk("rst_flags", 16'(Flags), 16'd0);
        chk("rst_err", 16'(Err), 16'd0);
        for (int i = 0; i < 4; i++) begin
            RdAddr = 2'(i); #1;
            chk("rst_reg", 16'(RdData), 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", 16'(CmdReady), 16'd1);

        // Signed overflow into 0x80.
        issue(4'b1000, 2'd0, 2'd0, 2'd1, 8'h7F);
        issue(4'b1000, 2'd0, 2'd0, 2'd2, 8'h01);
        issue(4'b0000, 2'd1, 2'd2, 2'd3, 8'h00);
        chk("r3_0x80", 16'(m_regs[3]), 16'h80);
        chk("flags_0110", 16'(Flags), 16'b0110);

        // Full aliasing: Ra = Rb = Rd.
        issue(4'b1000, 2'd0, 2'd0, 2'd0, 8'hFF);
        issue(4'b0000, 2'd0, 2'd0, 2'd0, 8'h00);
        chk("flags_1010", 16'(Flags), 16'b1010);

        issue(4'b1000, 2'd0, 2'd0, 2'd1, 8'h05);
        issue(4'b0001, 2'd1, 2'd1, 2'd2, 8'h00);
        chk("flags_0001", 16'(Flags), 16'b0001);

        // Illegal op, then a legal ADD that must not clear Err.
        issue(4'b1010, 2'd0, 2'd0, 2'd1, 8'h33);
        issue(4'b0000, 2'd1, 2'd2, 2'd0, 8'h00);
        chk("err_sticky", 16'(Err), 16'd1);

        issue(4'b1000, 2'd0, 2'd0, 2'd0, 8'h3C);
        issue(4'b1000, 2'd0, 2'd0, 2'd1, 8'hA5);
        for (int op = 2; op < 8; op++) begin
            issue(4'(op), 2'd0, 2'd1, 2'(op % 4), 8'h00);
        end
        issue(4'b1111, 2'd3, 2'd2, 2'd3, 8'hEE);

        // CmdValid held high: one accept and one completion every three cycles.
        r = alu_f(4'b0000, m_regs[1], m_regs[2]);
        e.data = r[7:0]; e.flags = r[11:8]; e.err = m_err;
        repeat (3) sb.push_back(e);
        m_regs[3] = r[7:0];
        m_flags   = r[11:8];
        acc = 0; dn = 0;
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = 4'b0000; CmdRa = 2'd1; CmdRb = 2'd2; CmdRd = 2'd3;
        RdAddr = 2'd3;
        for (int i = 0; i < 9; i++) begin
            acc += int'(CmdReady);
            if (DoneValid) begin
                dn++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("tp_done_data", 16'(DoneData), 16'(e.data));
                end
            end
            @(negedge clk);
        end
        CmdValid = 1'b0;
        chk("tp_accepts", 16'(acc), 16'd3);
        chk("tp_dones", 16'(dn), 16'd3);
        chk("tp_r3", 16'(RdData), 16'(m_regs[3]));
        chk("tp_flags", 16'(Flags), 16'(m_flags));
        sb.delete();

        // Reset in EXEC aborts the LOADI.
        @(negedge clk);
        CmdValid = 1'b1; CmdOp = 4'b1000; CmdRd = 2'd2; CmdImm = 8'h55; RdAddr = 2'd2;
        @(posedge clk); #1;
        CmdValid = 1'b0;
        chk("abort_in_exec", 16'(AluSel), 16'b1000);
        rst = 1'b1;
        #1;
        chk("abort_ready", 16'(CmdReady), 16'd0);
        chk("abort_alu_sel", 16'(AluSel), 16'd0);
        chk("abort_done", 16'(DoneValid), 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_r2", 16'(RdData), 16'd0);
        chk("abort_err_clear", 16'(Err), 16'd0);
        chk("abort_flags", 16'(Flags), 16'd0);
        chk("abort_ready_after", 16'(CmdReady), 16'd1);
        @(posedge clk); #1;
        chk("abort_no_done", 16'(DoneValid), 16'd0);
        chk("abort_idle", 16'(CmdReady), 16'd1);

        issue(4'b1000, 2'd0, 2'd0, 2'd3, 8'hA5);
        issue(4'b0110, 2'd3, 2'd0, 2'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
